arm_single_cycle_core: RTL and testbench
========================================

// Module: arm_single_cycle_core
// PURPOSE
// - Single-cycle 32-bit ARM-subset processor core; executes one instruction per clk.
// - Fetches from an external combinational instruction ROM via PC/Instr.
// - Accesses an external data memory via ALUResult/WriteData/MemWrite/ReadData.
//   Memory reads are combinational; writes occur on the clk edge.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value loaded while reset is asserted.
// PORTS
// - clk        in   1   system clock, rising edge active
// - reset      in   1   asynchronous, active-low reset
// - PC         out  32  current instruction address (byte address, word aligned)
// - Instr      in   32  instruction at PC (combinational from ROM)
// - MemWrite   out  1   data-memory write enable for this cycle
// - ALUResult  out  32  ALU output; data-memory address for LDR/STR
// - WriteData  out  32  store data (value of Rd) for STR
// - ReadData   in   32  data-memory read data at ALUResult (combinational)
// BEHAVIOUR
// - State: PC register, register file R0-R14 (16x32 array), NZCV flags.
// - Reset (reset==0, async): PC=RESET_PC, R0-R14=0, NZCV=0, MemWrite forced 0.
//   Release returns to normal fetch on the next rising clk.
// - Reading R15 returns PC+8. Writes to R15 are suppressed; only branches redirect PC.
// - Cond field Instr[31:28]: all 15 ARM codes (EQ..AL) against current NZCV; 4'hF = never.
//   Failed cond: no reg write, no flag update, MemWrite=0, PC+=4.
// - op=00, data processing:
//   - cmd 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; 1010 CMP (flags only, no Rd write).
//   - Operand2 with I=1: imm8 rotated right by 2*rot4.
//   - Operand2 with I=0: Rm; shift fields ignored.
//   - Other cmds execute as NOP.
//   - S=1 (forced for CMP): N=res[31], Z=(res==0).
//     ADD/SUB/CMP also set C = carry-out (SUB: C=NOT borrow) and V = signed overflow.
//     AND/ORR leave C,V unchanged.
// - op=01, LDR/STR, word only:
//   - Address = Rn +/- imm12 (U bit selects add/sub). ALUResult = address.
//   - Register offset (I=1), P=0, W=1 and B=1 forms execute as NOP.
//   - STR: MemWrite=1 and WriteData=Rd for the cycle; memory captures on the clk edge.
//   - LDR: Rd<=ReadData at the clk edge.
// - op=10, B: PC <= PC+8 + (sext(imm24)<<2). Bit 24 (L) is ignored unless ARM_BL_EN.
// - op=11: NOP, PC+=4.
// - Timing: all register, flag and PC updates occur at the rising clk edge.
//   MemWrite, ALUResult and WriteData are combinational from Instr and state.
// - Arithmetic is 32-bit modulo 2^32. PC wraps 0xFFFFFFFC -> 0x00000000.
// - WriteData = Rd value for every instruction; only meaningful when MemWrite=1.
// CONFIGURATION
// - ARM_BL_EN defined: B with L=1 (BL) also writes R14 <= PC+4 in the same cycle.
// - ARM_BL_EN undefined: BL behaves exactly as B; R14 untouched.
// TESTING
// - Reset: hold reset=0 -> PC=0, MemWrite=0. Release -> PC=0,4,8 on successive clk edges.
// - ALU: E2801005 (ADD R1,R0,#5) -> ALUResult=5. Then E2812003 -> ALUResult=8, R2=8.
// - Memory store/load:
//   - E5802064 (STR R2,[R0,#100]) -> MemWrite=1, ALUResult=100, WriteData=8.
//   - Then E5903064 with ReadData=8 -> R3=8, MemWrite=0.
// - Flags/conditions:
//   - E0514001 (SUBS R4,R1,R1) -> Z=1, C=1.
//   - Then 12805001 (ADDNE) -> R5 unchanged.
//   - 0A000001 (BEQ) at PC=0x18 -> next PC=0x24.
// - Branch/wrap: EAFFFFFE at PC=0x20 -> PC stays 0x20. Assert reset mid-loop -> PC=0 immediately.
// - ARM_BL_EN: EB000000 at PC=0x10 -> PC=0x18, R14=0x14. Without the macro R14 stays 0.

Source files
------------

// File: rtl/arm_single_cycle_core.sv
// Single-cycle ARM-subset core: DP (ADD/SUB/AND/ORR/CMP), word LDR/STR, B, full condition codes.
// Optional `ARM_BL_EN: B with L=1 also writes the return address PC+4 into R14.
module arm_single_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC,
    input  logic [31:0] Instr,
    output logic        MemWrite,
    output logic [31:0] ALUResult,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_SUB = 4'b0010,
        CMD_ADD = 4'b0100,
        CMD_CMP = 4'b1010,
        CMD_ORR = 4'b1100
    } dp_cmd_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [16];
    logic        n_q, z_q, c_q, v_q;

    logic [1:0]  op;
    logic [3:0]  cmd, rn, rd, rm;
    logic        imm_i, set_s;
    logic [31:0] pc_plus4, pc_plus8;
    logic [31:0] rn_val, rd_val, rm_val, op2, mem_addr;
    logic [63:0] imm_rot;
    logic        cond_pass, dp_valid, mem_valid, is_load;
    logic [31:0] alu_res;
    logic        alu_c, alu_v;
    logic [32:0] sum;
    logic        rf_we, bl_we, flags_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign op    = Instr[27:26];
    assign imm_i = Instr[25];
    assign cmd   = Instr[24:21];
    assign set_s = Instr[20];
    assign rn    = Instr[19:16];
    assign rd    = Instr[15:12];
    assign rm    = Instr[3:0];

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;

    // R15 reads as the pipelined PC+8, matching ARM's architectural view.
    assign rn_val = (rn == 4'd15) ? pc_plus8 : rf_q[rn];
    assign rd_val = (rd == 4'd15) ? pc_plus8 : rf_q[rd];
    assign rm_val = (rm == 4'd15) ? pc_plus8 : rf_q[rm];

    assign imm_rot = {24'd0, Instr[7:0], 24'd0, Instr[7:0]} >> {Instr[11:8], 1'b0};
    assign op2     = imm_i ? imm_rot[31:0] : rm_val;

    always_comb begin
        case (Instr[31:28])
            4'h0:    cond_pass = z_q;
            4'h1:    cond_pass = !z_q;
            4'h2:    cond_pass = c_q;
            4'h3:    cond_pass = !c_q;
            4'h4:    cond_pass = n_q;
            4'h5:    cond_pass = !n_q;
            4'h6:    cond_pass = v_q;
            4'h7:    cond_pass = !v_q;
            4'h8:    cond_pass = c_q && !z_q;
            4'h9:    cond_pass = !c_q || z_q;
            4'hA:    cond_pass = (n_q == v_q);
            4'hB:    cond_pass = (n_q != v_q);
            4'hC:    cond_pass = !z_q && (n_q == v_q);
            4'hD:    cond_pass = z_q || (n_q != v_q);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        alu_res  = 32'd0;
        alu_c    = c_q;
        alu_v    = v_q;
        sum      = 33'd0;
        dp_valid = 1'b1;
        case (dp_cmd_e'(cmd))
            CMD_ADD: begin
                sum     = {1'b0, rn_val} + {1'b0, op2};
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (rn_val[31] == op2[31]) && (alu_res[31] != rn_val[31]);
            end
            CMD_SUB, CMD_CMP: begin
                sum     = {1'b0, rn_val} + {1'b0, ~op2} + 33'd1;
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (rn_val[31] != op2[31]) && (alu_res[31] != rn_val[31]);
            end
            CMD_AND: alu_res = rn_val & op2;
            CMD_ORR: alu_res = rn_val | op2;
            default: dp_valid = 1'b0;
        endcase
    end

    // Only immediate-offset, pre-indexed, no-writeback word transfers are supported.
    assign mem_valid = (op == 2'b01) && !imm_i && Instr[24] && !Instr[22] && !Instr[21];
    assign is_load   = Instr[20];
    assign mem_addr  = Instr[23] ? rn_val + {20'd0, Instr[11:0]} : rn_val - {20'd0, Instr[11:0]};

    assign PC        = pc_q;
    assign ALUResult = (op == 2'b01) ? mem_addr : alu_res;
    assign WriteData = rd_val;
    assign MemWrite  = reset && cond_pass && mem_valid && !is_load;

`ifdef ARM_BL_EN
    assign bl_we = cond_pass && (op == 2'b10) && Instr[24];
`else
    assign bl_we = 1'b0;
`endif

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = alu_res;
        if (bl_we) begin
            rf_we    = 1'b1;
            rf_waddr = 4'd14;
            rf_wdata = pc_plus4;
        end else if (cond_pass && rd != 4'd15) begin
            if (op == 2'b00 && dp_valid && cmd != CMD_CMP) begin
                rf_we = 1'b1;
            end else if (mem_valid && is_load) begin
                rf_we    = 1'b1;
                rf_wdata = ReadData;
            end
        end
    end

    assign flags_we = cond_pass && (op == 2'b00) && dp_valid && (set_s || cmd == CMD_CMP);
    assign pc_d     = (cond_pass && op == 2'b10)
                    ? pc_plus8 + {{6{Instr[23]}}, Instr[23:0], 2'b00}
                    : pc_plus4;

    // NOTE: sequential state uses non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            // NOTE: the register file is architecturally cleared by reset, so the array is reset too.
            for (int i = 0; i < 16; i++) rf_q[i] <= 32'd0;
            {n_q, z_q, c_q, v_q} <= 4'b0000;
        end else begin
            pc_q <= pc_d;
            if (rf_we) rf_q[rf_waddr] <= rf_wdata;
            if (flags_we) {n_q, z_q, c_q, v_q} <= {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};
        end
    end

endmodule

// File: tb/tb_arm_single_cycle_core.sv
// Scoreboard bench for arm_single_cycle_core: the bench acts as instruction ROM and data memory.
module tb_arm_single_cycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PC;
    logic [31:0] Instr = 32'hEC00_0000;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData = 32'd0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic        mw;
        logic [31:0] alu;
        logic        chk_alu;
        logic [31:0] wd;
        logic        chk_wd;
    } step_t;

    step_t exp_q[$];
    step_t obs_q[$];

    localparam logic [31:0] NOP = 32'hEC00_0000;

    arm_single_cycle_core dut (
        .clk       (clk),
        .reset     (reset),
        .PC        (PC),
        .Instr     (Instr),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic step_t mk(input logic [31:0] pc, input logic mw, input logic [31:0] alu,
                                 input logic ca, input logic [31:0] wd, input logic cw);
        step_t s;
        s.pc = pc; s.mw = mw; s.alu = alu; s.chk_alu = ca; s.wd = wd; s.chk_wd = cw;
        return s;
    endfunction

    // Called at a negedge: drive one instruction, record expected and observed, advance one cycle.
    task automatic exec(input logic [31:0] ins, input logic [31:0] rdata, input step_t e);
        step_t o;
        Instr = ins;
        ReadData = rdata;
        #1;
        o = mk(PC, MemWrite, ALUResult, 1'b0, WriteData, 1'b0);
        exp_q.push_back(e);
        obs_q.push_back(o);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        Instr = 32'hE580_2064;
        #1;
        checks++;
        if (PC !== 32'd0) begin failures++; $display("FAIL reset_pc got %h want 00000000", PC); end
        checks++;
        if (MemWrite !== 1'b0) begin failures++; $display("FAIL reset_memwrite got %b want 0", MemWrite); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (PC !== 32'd0) begin failures++; $display("FAIL reset_hold_pc got %h want 00000000", PC); end
        Instr = NOP;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (PC !== 32'(i * 4)) begin
                failures++;
                $display("FAIL release_pc[%0d] got %h want %h", i, PC, 32'(i * 4));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_mem();
        step_t e, o;
        do_reset();
        exec(32'hE280_1005, 32'd0, mk(32'h00, 1'b0, 32'd5,   1'b1, 32'd0, 1'b1));
        exec(32'hE281_2003, 32'd0, mk(32'h04, 1'b0, 32'd8,   1'b1, 32'd0, 1'b1));
        exec(32'hE580_2064, 32'd0, mk(32'h08, 1'b1, 32'd100, 1'b1, 32'd8, 1'b1));
        exec(32'hE590_3064, 32'd8, mk(32'h0C, 1'b0, 32'd100, 1'b1, 32'd0, 1'b1));
        exec(32'hE580_3000, 32'd0, mk(32'h10, 1'b1, 32'd0,   1'b1, 32'd8, 1'b1));
        exec(32'hE28F_9000, 32'd0, mk(32'h14, 1'b0, 32'h1C,  1'b1, 32'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.pc !== e.pc) begin failures++; $display("FAIL alu_mem pc got %h want %h", o.pc, e.pc); end
            checks++;
            if (o.mw !== e.mw) begin failures++; $display("FAIL alu_mem memwrite@%h got %b want %b", e.pc, o.mw, e.mw); end
            if (e.chk_alu) begin
                checks++;
                if (o.alu !== e.alu) begin failures++; $display("FAIL alu_mem aluresult@%h got %h want %h", e.pc, o.alu, e.alu); end
            end
            if (e.chk_wd) begin
                checks++;
                if (o.wd !== e.wd) begin failures++; $display("FAIL alu_mem writedata@%h got %h want %h", e.pc, o.wd, e.wd); end
            end
        end
    endtask

    task automatic test_flags_cond();
        step_t e, o;
        exec(32'hE051_4001, 32'd0, mk(32'h18, 1'b0, 32'd0,         1'b1, 32'd0, 1'b1));
        exec(32'h1280_5001, 32'd0, mk(32'h1C, 1'b0, 32'd0,         1'b0, 32'd0, 1'b1));
        exec(32'h0A00_0001, 32'd0, mk(32'h20, 1'b0, 32'd0,         1'b0, 32'd0, 1'b0));
        exec(32'hE580_5004, 32'd0, mk(32'h2C, 1'b1, 32'd4,         1'b1, 32'd0, 1'b1));
        exec(32'hE280_6102, 32'd0, mk(32'h30, 1'b0, 32'h8000_0000, 1'b1, 32'd0, 1'b0));
        exec(32'hE256_7001, 32'd0, mk(32'h34, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'd0, 1'b0));
        exec(32'h6580_0008, 32'd0, mk(32'h38, 1'b1, 32'd8,         1'b1, 32'd0, 1'b1));
        exec(32'h4580_0008, 32'd0, mk(32'h3C, 1'b0, 32'd8,         1'b1, 32'd0, 1'b0));
        exec(32'hF580_0008, 32'd0, mk(32'h40, 1'b0, 32'd8,         1'b1, 32'd0, 1'b0));
        exec(32'h2580_0008, 32'd0, mk(32'h44, 1'b1, 32'd8,         1'b1, 32'd0, 1'b0));
        exec(32'hE186_8007, 32'd0, mk(32'h48, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0));
        exec(32'hE351_0005, 32'd0, mk(32'h4C, 1'b0, 32'd0,         1'b1, 32'd0, 1'b0));
        exec(32'h0580_0000, 32'd0, mk(32'h50, 1'b1, 32'd0,         1'b1, 32'd0, 1'b1));
        exec(32'hC580_0000, 32'd0, mk(32'h54, 1'b0, 32'd0,         1'b1, 32'd0, 1'b0));
        exec(32'hA580_0000, 32'd0, mk(32'h58, 1'b1, 32'd0,         1'b1, 32'd0, 1'b0));
        exec(32'hE011_A007, 32'd0, mk(32'h5C, 1'b0, 32'd5,         1'b1, 32'd0, 1'b0));
        exec(32'h8580_0000, 32'd0, mk(32'h60, 1'b1, 32'd0,         1'b1, 32'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.pc !== e.pc) begin failures++; $display("FAIL flags pc got %h want %h", o.pc, e.pc); end
            checks++;
            if (o.mw !== e.mw) begin failures++; $display("FAIL flags memwrite@%h got %b want %b", e.pc, o.mw, e.mw); end
            if (e.chk_alu) begin
                checks++;
                if (o.alu !== e.alu) begin failures++; $display("FAIL flags aluresult@%h got %h want %h", e.pc, o.alu, e.alu); end
            end
            if (e.chk_wd) begin
                checks++;
                if (o.wd !== e.wd) begin failures++; $display("FAIL flags writedata@%h got %h want %h", e.pc, o.wd, e.wd); end
            end
        end
    endtask

    task automatic test_branch_wrap();
        step_t e, o;
        for (int i = 0; i < 3; i++)
            exec(32'hEAFF_FFFE, 32'd0, mk(32'h64, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
        // Asynchronous reset in the middle of the self-loop, away from any clock edge.
        @(posedge clk);
        Instr = 32'hE580_2064;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (PC !== 32'd0) begin failures++; $display("FAIL midloop_reset_pc got %h want 00000000", PC); end
        checks++;
        if (MemWrite !== 1'b0) begin failures++; $display("FAIL midloop_reset_memwrite got %b want 0", MemWrite); end
        @(negedge clk);
        reset = 1'b1;
        exec(32'hEAFF_FFFD, 32'd0, mk(32'h0000_0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
        exec(NOP,           32'd0, mk(32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
        exec(NOP,           32'd0, mk(32'h0000_0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.pc !== e.pc) begin failures++; $display("FAIL branch pc got %h want %h", o.pc, e.pc); end
            checks++;
            if (o.mw !== e.mw) begin failures++; $display("FAIL branch memwrite@%h got %b want %b", e.pc, o.mw, e.mw); end
        end
    endtask

    task automatic test_bl();
        step_t e, o;
        logic [31:0] exp_r14;
`ifdef ARM_BL_EN
        exp_r14 = 32'h14;
`else
        exp_r14 = 32'h0;
`endif
        do_reset();
        for (int i = 0; i < 4; i++)
            exec(NOP, 32'd0, mk(32'(i * 4), 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
        exec(32'hEB00_0000, 32'd0, mk(32'h10, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
        exec(32'hE580_E000, 32'd0, mk(32'h18, 1'b1, 32'd0, 1'b1, exp_r14, 1'b1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.pc !== e.pc) begin failures++; $display("FAIL bl pc got %h want %h", o.pc, e.pc); end
            checks++;
            if (o.mw !== e.mw) begin failures++; $display("FAIL bl memwrite@%h got %b want %b", e.pc, o.mw, e.mw); end
            if (e.chk_alu) begin
                checks++;
                if (o.alu !== e.alu) begin failures++; $display("FAIL bl aluresult@%h got %h want %h", e.pc, o.alu, e.alu); end
            end
            if (e.chk_wd) begin
                checks++;
                if (o.wd !== e.wd) begin failures++; $display("FAIL bl r14@%h got %h want %h", e.pc, o.wd, e.wd); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_mem();
        test_flags_cond();
        test_branch_wrap();
        test_bl();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
